ctrl_fetch_sequencer: RTL

- Sequences the single-port control-word BRAM for the LUD hardware.
- In IDLE/DONE the BRAM port belongs to the Zynq host for program load and readback.
- During a run it streams control words from address 0 upward into a small prefetch FIFO and hands them to the datapath decoder over a valid/ready handshake.
- Stops fetching on the word whose completion bit (bit 0) is set, drains the FIFO, then reports DONE.

---
 rtl/ctrl_fetch_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ctrl_fetch_sequencer.sv
// Control-word fetch sequencer: streams LUD control words from the shared BRAM into a small
// prefetch FIFO during a run and hands the BRAM port back to the Zynq host when idle or done.
module ctrl_fetch_sequencer #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned CTRL_WIDTH = 60,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  CLK_100,
   input  logic                  RST,
   input  logic                  START,
   input  logic [ADDR_WIDTH-1:0] HOST_addr,
   input  logic [CTRL_WIDTH-1:0] HOST_din,
   input  logic                  HOST_en,
   input  logic                  HOST_we,
   output logic [CTRL_WIDTH-1:0] HOST_dout,
   output logic                  HOST_BLOCKED,
   output logic [ADDR_WIDTH-1:0] BRAM_addr,
   output logic [CTRL_WIDTH-1:0] BRAM_din,
   output logic                  BRAM_en,
   output logic                  BRAM_we,
   input  logic [CTRL_WIDTH-1:0] BRAM_dout,
   output logic [CTRL_WIDTH-1:0] CTRL_WORD,
   output logic                  CTRL_VALID,
   input  logic                  CTRL_READY,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR_WRAP,
   output logic [1:0]            STATE
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StFetch = 2'b01,
      StDrain = 2'b10,
      StDone  = 2'b11
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  inflight_q, inflight_d;
   logic                  last_q, last_d;
   logic                  err_q, err_d;
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic [CTRL_WIDTH-1:0] fifo_q [FIFO_DEPTH];

   logic            busy;
   logic            ret_done;
   logic [CntW:0]   occupancy;
   logic            room;
   logic            issue;
   logic            push;
   logic            pop;
   logic            flush;

   assign busy      = (state_q == StFetch) || (state_q == StDrain);
   assign ret_done  = inflight_q & BRAM_dout[0];
   assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
   assign room      = occupancy < (CntW + 1)'(FIFO_DEPTH);
   // A returning completion word suppresses the issue in the same cycle, so nothing past it is read.
   assign issue     = (state_q == StFetch) & START & ~last_q & ~ret_done & room;
   assign push      = (state_q == StFetch) & START & inflight_q;
   assign pop       = CTRL_VALID & CTRL_READY;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      last_d     = last_q;
      err_d      = err_q;
      inflight_d = issue;
      flush      = 1'b0;
      wr_ptr_d   = wr_ptr_q + PtrW'(push);
      rd_ptr_d   = rd_ptr_q + PtrW'(pop);
      count_d    = count_q + CntW'(push) - CntW'(pop);

      unique case (state_q)
         StIdle: begin
            if (START) begin
               state_d = StFetch;
               addr_d  = '0;
               last_d  = 1'b0;
               err_d   = 1'b0;
               flush   = 1'b1;
            end
         end
         StFetch: begin
            if (!START) begin
               state_d = StIdle;
               flush   = 1'b1;
            end else begin
               if (issue) begin
                  addr_d = addr_q + ADDR_WIDTH'(1);
                  if (addr_q == LastAddr) last_d = 1'b1;
               end
               if (inflight_q) begin
                  if (BRAM_dout[0]) begin
                     state_d = StDrain;
                  end else if (last_q) begin
                     // Final address came back without a completion bit.
                     err_d   = 1'b1;
                     state_d = StDrain;
                  end
               end
            end
         end
         StDrain: begin
            if (!START) begin
               state_d = StIdle;
               flush   = 1'b1;
            end else if (count_d == '0 && !inflight_q) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (!START) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         inflight_d = 1'b0;
      end
   end

   always_ff @(posedge CLK_100) begin
      if (RST) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         last_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         last_q     <= last_d;
         err_q      <= err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: the count gates every read of it.
   always_ff @(posedge CLK_100) begin
      if (push) fifo_q[wr_ptr_q] <= BRAM_dout;
   end

   always_comb begin
      CTRL_VALID   = (count_q != '0);
      CTRL_WORD    = CTRL_VALID ? fifo_q[rd_ptr_q] : '0;
      BUSY         = busy;
      HOST_BLOCKED = busy;
      DONE         = (state_q == StDone);
      ERR_WRAP     = err_q;
      STATE        = state_q;
      HOST_dout    = BRAM_dout;
      if (busy) begin
         BRAM_addr = addr_q;
         BRAM_din  = '0;
         BRAM_en   = issue;
         BRAM_we   = 1'b0;
      end else begin
         BRAM_addr = HOST_addr;
         BRAM_din  = HOST_din;
         BRAM_en   = HOST_en;
         BRAM_we   = HOST_we;
      end
   end

endmodule
